uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
UART transmitter that drains the dequeue side of the team's byte FIFO. It monitors the FIFO's empty flag, pulses deq to pop one byte, and serialises it as 8N1 on tx, LSB first. It sits between the FIFO and the FPGA tx pin and is the outbound counterpart to the FIFO writer. It transmits back-to-back until the FIFO is empty.

Parameters:
WIDTH, 8, data bits per frame; must match the FIFO WIDTH.
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum legal value 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
fifo_empty  input  1  FIFO empty flag; 1 means no data.
fifo_dout  input  WIDTH  FIFO read data; valid in the cycle after the cycle in which deq was asserted.
fifo_deq  output  WIDTH=1  one-cycle dequeue strobe to the FIFO.
tx  output  1  serial line; idle high.
busy  output  1  high from FETCH until the end of STOP.
tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high, sampled on rising clk.
- Reset values: tx=1, fifo_deq=0, busy=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: tx=1, busy=0. If fifo_empty=0, go to FETCH on the next edge. Otherwise stay in IDLE.
- FETCH: lasts exactly 1 cycle. fifo_deq=1, busy=1. Always go to LOAD.
- LOAD: lasts exactly 1 cycle. fifo_deq=0. Capture fifo_dout into the shift register. Clear the baud counter. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles. Go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index.
  - After WIDTH bits, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle.
  - On that final cycle, if fifo_empty=0, go to FETCH; otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Width is $clog2(CLKS_PER_BIT).
  - No drift is allowed; a frame is exactly (WIDTH+2)*CLKS_PER_BIT cycles.
- Inter-frame gap: back-to-back frames carry exactly 2 extra idle-high cycles (FETCH and LOAD) between the stop bit and the next start bit.
- Idle start latency: 1 cycle after fifo_empty falls (IDLE to FETCH), 2 cycles before tx falls. That gives 3 cycles from the edge where fifo_empty=0 is first sampled to the first tx=0 cycle.
- fifo_deq:
  - Asserted only in FETCH, and only while fifo_empty=0 was sampled.
  - Never asserted twice per byte.
  - Never asserted while fifo_empty=1. No underflow.
- tx is registered; no combinational path from inputs to tx.
- fifo_empty changes during a frame have no effect until the STOP decision.
- Reset mid-frame: on the next edge all outputs return to reset values and tx goes high immediately. The in-flight byte is discarded and is not re-fetched. FIFO contents are untouched.
- reset has priority over all state transitions.
- X-safety: fifo_dout is captured only in LOAD.

Test Plan:
(Bench uses CLKS_PER_BIT=4, WIDTH=8, and the existing FIFO as source.)
1. Single byte: reset 3 cycles, then enqueue 8'hA5.
   - Exactly one fifo_deq pulse.
   - tx reads 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit held 4 cycles.
   - One tx_done pulse; FSM returns to IDLE with busy=0.
2. Back-to-back: enqueue 8'h11,8'h22,8'h33 before the first frame starts.
   - The bench UART decoder recovers 11,22,33 in order.
   - Gap between each stop bit end and the next start bit is exactly 2 cycles.
   - 3 deq pulses; FIFO ends empty.
3. Empty FIFO: hold reset low with no enqueues for 200 cycles.
   - tx=1, fifo_deq=0, busy=0 throughout.
4. Frame length: enqueue 8'h00 and measure from the tx falling edge to the tx_done pulse.
   - Exactly 40 cycles: start bit plus 8 zero data bits at 4 cycles each = 36 low cycles, then a 4-cycle stop bit with tx_done on its last cycle.
5. Reset mid-frame: enqueue 8'hFF,8'h0F; assert reset for 1 cycle during DATA bit 3 of the first frame.
   - tx=1 on the next edge.
   - After reset, the next frame sent is 8'h0F; 8'hFF is not retransmitted.
6. Late arrival: enqueue 8'h5A while the STOP bit of an 8'h3C frame is in progress.
   - The 5A frame follows with the 2-cycle gap.
   - Decoded sequence is 3C, 5A.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that pops bytes from a FIFO and sends them back-to-back.
// tx is registered from the next-state decode so it has no input-to-pin path.
module uart_tx_fifo_drain #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_deq,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [BW-1:0]    baud, baud_nxt;
    logic [IW-1:0]    bitc, bitc_nxt;
    logic [WIDTH-1:0] shift, shift_nxt;
    logic             tx_nxt;
    logic             last;

    assign last     = (baud == BAUD_LAST);
    assign fifo_deq = (state == FETCH);
    assign busy     = (state != IDLE);
    assign tx_done  = (state == STOP) && last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            baud  <= '0;
            bitc  <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_nxt;
            baud  <= baud_nxt;
            bitc  <= bitc_nxt;
            shift <= shift_nxt;
            tx    <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bitc_nxt  = bitc;
        shift_nxt = shift;
        tx_nxt    = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = FETCH;
            end
            FETCH: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                shift_nxt = fifo_dout;
                baud_nxt  = '0;
                bitc_nxt  = '0;
                state_nxt = START;
            end
            START: begin
                if (last) begin
                    baud_nxt  = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            DATA: begin
                if (last) begin
                    baud_nxt  = '0;
                    shift_nxt = shift >> 1;
                    if (bitc == BIT_LAST) begin
                        bitc_nxt  = '0;
                        state_nxt = STOP;
                    end else begin
                        bitc_nxt = bitc + 1'b1;
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            STOP: begin
                if (last) begin
                    baud_nxt  = '0;
                    state_nxt = fifo_empty ? IDLE : FETCH;
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Line level follows the state being entered, so tx flips on the edge.
        unique case (1'b1)
            (state_nxt == START): tx_nxt = 1'b0;
            (state_nxt == DATA):  tx_nxt = shift_nxt[0];
            default:              tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with a small behavioural FIFO source.
// Samples everything on the falling edge; CLKS_PER_BIT is 4.
module tb_uart_tx_fifo_drain;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_deq;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    int checks = 0;
    int fails  = 0;
    int deq_cnt = 0;
    int done_cnt = 0;
    int underflow = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(
        .WIDTH       (8),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_deq  (fifo_deq),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_deq) begin
            fifo_dout <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_deq) deq_cnt <= deq_cnt + 1;
        if (fifo_deq && fifo_empty) underflow <= underflow + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr++;
    endtask

    // Leaves the bench on the first tx=0 cycle; n = ticks taken.
    task automatic wait_start(input string tag, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            n++;
            if (tx === 1'b0) found = 1'b1;
        end
        if (!found) check(tag, {31'd0, found}, 32'd1);
    endtask

    // Entered on start-bit cycle 0; leaves on the last stop-bit cycle.
    task automatic recv(output logic [7:0] b);
        b = 8'h00;
        repeat (2) tick();
        check("start_bit", {31'd0, tx}, 32'd0);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            b[i] = tx;
            if (i < 7) repeat (4) tick();
        end
        repeat (2) tick();
        check("stop_bit", {31'd0, tx}, 32'd1);
        repeat (3) tick();
        check("tx_done_pulse", {31'd0, tx_done}, 32'd1);
    endtask

    initial begin
        int n;
        int lows;
        int d0;
        int c0;
        logic [7:0] b;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_deq", {31'd0, fifo_deq}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single byte A5
        d0 = deq_cnt;
        c0 = done_cnt;
        push(8'hA5);
        wait_start("t1_start", n);
        check("t1_latency", n, 32'd3);
        recv(b);
        check("t1_byte", {24'd0, b}, 32'hA5);
        repeat (2) tick();
        check("t1_busy_idle", {31'd0, busy}, 32'd0);
        check("t1_deq_count", deq_cnt - d0, 32'd1);
        check("t1_done_count", done_cnt - c0, 32'd1);

        // 2: back-to-back 11,22,33
        d0 = deq_cnt;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_start("t2_start0", n);
        recv(b);
        check("t2_byte0", {24'd0, b}, 32'h11);
        wait_start("t2_start1", n);
        check("t2_gap1", n - 1, 32'd2);
        recv(b);
        check("t2_byte1", {24'd0, b}, 32'h22);
        wait_start("t2_start2", n);
        check("t2_gap2", n - 1, 32'd2);
        recv(b);
        check("t2_byte2", {24'd0, b}, 32'h33);
        repeat (3) tick();
        check("t2_deq_count", deq_cnt - d0, 32'd3);
        check("t2_fifo_empty", {31'd0, fifo_empty}, 32'd1);

        // 3: empty FIFO stays idle
        for (int i = 0; i < 200; i++) begin
            tick();
            check("t3_idle", {29'd0, tx, fifo_deq, busy}, 32'b100);
        end

        // 4: frame length for 00
        push(8'h00);
        wait_start("t4_start", n);
        n = 1;
        lows = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (tx === 1'b0) lows++;
            if (tx_done === 1'b1) break;
        end
        check("t4_frame_len", n, 32'd40);
        check("t4_low_cycles", lows, 32'd36);
        repeat (4) tick();

        // 5: reset during data bit 3 of FF
        d0 = deq_cnt;
        push(8'hFF);
        push(8'h0F);
        wait_start("t5_start", n);
        repeat (17) tick();
        reset = 1'b1;
        tick();
        check("t5_rst_tx", {31'd0, tx}, 32'd1);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wait_start("t5_restart", n);
        recv(b);
        check("t5_byte", {24'd0, b}, 32'h0F);
        repeat (4) tick();
        check("t5_deq_count", deq_cnt - d0, 32'd2);
        check("t5_fifo_empty", {31'd0, fifo_empty}, 32'd1);

        // 6: late arrival during stop bit
        push(8'h3C);
        wait_start("t6_start0", n);
        recv(b);
        check("t6_byte0", {24'd0, b}, 32'h3C);
        push(8'h5A);
        wait_start("t6_start1", n);
        check("t6_gap", n - 1, 32'd2);
        recv(b);
        check("t6_byte1", {24'd0, b}, 32'h5A);
        repeat (5) tick();
        check("t6_busy_idle", {31'd0, busy}, 32'd0);
        check("no_underflow", underflow, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
